// File: rtl/des_pkg.sv
// Shared DES definitions: widths, permutation tables, S-box contents and the
// reverse key-rotation schedule used by the iterative decrypt core.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int HALF_W   = 32;
    localparam int KEY_W    = 56;
    localparam int SUBKEY_W = 48;

    typedef enum logic {IDLE, RUN} state_t;

    // All tables use DES numbering: entry j gives the 1-based input bit (MSB = bit 1).
    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int unsigned FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Right-rotation applied after round n is RS[n+1]; entries 0 and 1 are unused.
    localparam logic [1:0] RS [17] = '{
        2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Each S-box packed row-major, entry (row*16+col) at nibble index from the MSB.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [BLOCK_W-1:0] perm_ip(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] perm_fp(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] perm_e(input logic [HALF_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [HALF_W-1:0] perm_p(input logic [HALF_W-1:0] x);
        logic [HALF_W-1:0] y;
        y = '0;
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    function automatic logic [KEY_W-1:0] perm_pc1(input logic [BLOCK_W-1:0] x);
        logic [KEY_W-1:0] y;
        y = '0;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] perm_pc2(input logic [KEY_W-1:0] x);
        logic [SUBKEY_W-1:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] y;
        case (n)
            2'd1:    y = {x[0], x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic key_parity_err(input logic [BLOCK_W-1:0] k);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) if (~^k[6'(8 * b) +: 8]) err = 1'b1;
        return err;
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [2:0] idx, input logic [5:0] bin);
        logic [5:0] entry;
        logic [7:0] msb;
        entry = {bin[5], bin[0], bin[4:1]};
        msb   = 8'd255 - {entry, 2'b00};
        return SBOX[idx][msb -: 4];
    endfunction

endpackage

// File: rtl/des_decrypt_iter_if.sv
// Request/response bundle between the block-cipher control logic and the decrypt core.
interface des_decrypt_iter_if;
    import des_pkg::*;

    logic               start;
    logic [BLOCK_W-1:0] din;
    logic [BLOCK_W-1:0] key;
    logic               busy;
    logic               done;
    logic [BLOCK_W-1:0] dout;
    logic               key_err;

    modport master (output start, din, key, input busy, done, dout, key_err);
    modport slave  (input start, din, key, output busy, done, dout, key_err);
endinterface

// File: rtl/des_f.sv
// DES round function f(R,K): expansion, key mix, S-box substitution and P.
// Purely combinational; shared by the encrypt and decrypt datapaths.
module des_f
    import des_pkg::*;
(
    input  logic [HALF_W-1:0]   r,
    input  logic [SUBKEY_W-1:0] k,
    output logic [HALF_W-1:0]   fout
);
    logic [SUBKEY_W-1:0] x;
    logic [HALF_W-1:0]   s;

    assign x = perm_e(r) ^ k;

    // Group 1 is the most significant six bits.
    sbox1 u_s1 (.bin(x[47:42]), .bsout(s[31:28]));
    sbox2 u_s2 (.bin(x[41:36]), .bsout(s[27:24]));
    sbox3 u_s3 (.bin(x[35:30]), .bsout(s[23:20]));
    sbox4 u_s4 (.bin(x[29:24]), .bsout(s[19:16]));
    sbox5 u_s5 (.bin(x[23:18]), .bsout(s[15:12]));
    sbox6 u_s6 (.bin(x[17:12]), .bsout(s[11:8]));
    sbox7 u_s7 (.bin(x[11:6]),  .bsout(s[7:4]));
    sbox8 u_s8 (.bin(x[5:0]),   .bsout(s[3:0]));

    assign fout = perm_p(s);
endmodule

module sbox1 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd0, bin);
endmodule

module sbox2 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd1, bin);
endmodule

module sbox3 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd2, bin);
endmodule

module sbox4 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd3, bin);
endmodule

module sbox5 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd4, bin);
endmodule

module sbox6 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd5, bin);
endmodule

module sbox7 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd6, bin);
endmodule

module sbox8 (input logic [5:0] bin, output logic [3:0] bsout);
    assign bsout = des_pkg::sbox_lookup(3'd7, bin);
endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1
// generated on the fly by right-rotating C/D.
//   state | meaning
//   IDLE  | waiting for start; dout holds the last plaintext
//   RUN   | rounds 1..16 in progress, round counter = current round
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    des_decrypt_iter_if.slave bus
);
    state_t              state;
    logic [4:0]          round;
    logic [HALF_W-1:0]   l;
    logic [HALF_W-1:0]   r;
    logic [27:0]         c;
    logic [27:0]         d;
    logic                busy;
    logic                done;
    logic                key_err;
    logic [BLOCK_W-1:0]  dout;
    logic [SUBKEY_W-1:0] subkey;
    logic [HALF_W-1:0]   f_out;
    logic [1:0]          shift;

    // C16 equals C0, so round 1 uses the PC1 output directly.
    assign subkey = perm_pc2({c, d});
    assign shift  = (round < 5'd16) ? RS[round + 5'd1] : 2'd0;

    des_f u_f (
        .r    (r),
        .k    (subkey),
        .fout (f_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            round   <= '0;
            l       <= '0;
            r       <= '0;
            c       <= '0;
            d       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            key_err <= 1'b0;
            dout    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        {l, r}  <= perm_ip(bus.din);
                        {c, d}  <= perm_pc1(bus.key);
                        round   <= 5'd1;
                        busy    <= 1'b1;
                        key_err <= PARITY_CHECK && key_parity_err(bus.key);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    l <= r;
                    r <= l ^ f_out;
                    c <= rotr28(c, shift);
                    d <= rotr28(d, shift);
                    if (round == 5'd16) begin
                        // Final swap: output is FP(R16 || L16).
                        dout  <= perm_fp({l ^ f_out, r});
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        round <= '0;
                        state <= IDLE;
                    end else begin
                        round <= round + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.dout    = dout;
    assign bus.key_err = key_err;
endmodule
